// File: rtl/sync_edge_debounce.sv
// ============================================================================
// Module   : sync_edge_debounce
// Brief    : Stability-qualified debouncer with edge strobes and a rising-edge
//            counter. Optional macro EDGE_CNT_SAT_EN makes the counter saturate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_syn,
    input  logic             cnt_clr,
    output logic             sig_clean,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam logic [7:0] c_stab_last = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_stab;
    logic       w_rise_accept;

    assign w_rise_accept = (r_state == WAIT_HI) && sig_syn && (r_stab == c_stab_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE_LO;
            r_stab     <= 8'd0;
            sig_clean  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (r_state)
                IDLE_LO: begin
                    if (sig_syn) begin
                        r_state <= WAIT_HI;
                        r_stab  <= 8'd1;
                    end
                end
                WAIT_HI: begin
                    if (!sig_syn) begin
                        r_state <= IDLE_LO;
                        r_stab  <= 8'd0;
                    end else if (r_stab == c_stab_last) begin
                        r_state    <= IDLE_HI;
                        r_stab     <= 8'd0;
                        sig_clean  <= 1'b1;
                        rise_pulse <= 1'b1;
                    end else begin
                        r_stab <= r_stab + 8'd1;
                    end
                end
                IDLE_HI: begin
                    if (!sig_syn) begin
                        r_state <= WAIT_LO;
                        r_stab  <= 8'd1;
                    end
                end
                WAIT_LO: begin
                    if (sig_syn) begin
                        r_state <= IDLE_HI;
                        r_stab  <= 8'd0;
                    end else if (r_stab == c_stab_last) begin
                        r_state    <= IDLE_LO;
                        r_stab     <= 8'd0;
                        sig_clean  <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else begin
                        r_stab <= r_stab + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE_LO;
                    r_stab  <= 8'd0;
                end
            endcase
        end
    end

    // Clear beats a coincident increment, so that edge is intentionally lost.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            edge_cnt <= '0;
        end else if (w_rise_accept) begin
`ifdef EDGE_CNT_SAT_EN
            if (edge_cnt != {CNT_W{1'b1}}) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
`else
            edge_cnt <= edge_cnt + 1'b1;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sync_edge_debounce.sv
// ============================================================================
// Module   : tb_sync_edge_debounce
// Brief    : Directed self-checking bench for sync_edge_debounce.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_edge_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sig_syn = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       sig_clean, rise_pulse, fall_pulse;
    logic [7:0] edge_cnt;

    logic       sig2 = 1'b0;
    logic       clr2 = 1'b0;
    logic       clean2, rise2, fall2;
    logic [1:0] cnt2;

    int n_cmp = 0;
    int n_bad = 0;
    int rises = 0;
    int falls = 0;
    int both  = 0;
    int r3    = 0;
    int f3    = 0;
    logic [1:0] exp2 [5];

    always #10 clk = ~clk;

    sync_edge_debounce #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .sig_syn(sig_syn), .cnt_clr(cnt_clr),
        .sig_clean(sig_clean), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .edge_cnt(edge_cnt)
    );

    sync_edge_debounce #(.STABLE_CYCLES(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .sig_syn(sig2), .cnt_clr(clr2),
        .sig_clean(clean2), .rise_pulse(rise2),
        .fall_pulse(fall2), .edge_cnt(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, sampling 1 ns after each edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rise_pulse) rises++;
            if (fall_pulse) falls++;
            if (rise_pulse && fall_pulse) both++;
        end
    endtask

    initial begin
        run(3);
        chk("rst_clean", 32'(sig_clean), 0);
        chk("rst_rise", 32'(rise_pulse), 0);
        chk("rst_fall", 32'(fall_pulse), 0);
        chk("rst_cnt", 32'(edge_cnt), 0);
        rst = 1'b0;
        run(1);
        chk("idle_clean", 32'(sig_clean), 0);

        // First accepted rise: edges 1..4
        sig_syn = 1'b1;
        run(3);
        chk("pre_rise_clean", 32'(sig_clean), 0);
        chk("pre_rise_pulse", 32'(rise_pulse), 0);
        run(1);
        chk("rise_clean", 32'(sig_clean), 1);
        chk("rise_pulse", 32'(rise_pulse), 1);
        chk("rise_cnt", 32'(edge_cnt), 1);
        run(1);
        chk("rise_pulse_end", 32'(rise_pulse), 0);

        sig_syn = 1'b0;
        run(3);
        chk("pre_fall_clean", 32'(sig_clean), 1);
        run(1);
        chk("fall_clean", 32'(sig_clean), 0);
        chk("fall_pulse", 32'(fall_pulse), 1);
        run(1);
        chk("fall_pulse_end", 32'(fall_pulse), 0);

        // Three-cycle high glitch from IDLE_LO
        rises = 0; falls = 0;
        sig_syn = 1'b1; run(3);
        sig_syn = 1'b0; run(5);
        chk("glitch_hi_clean", 32'(sig_clean), 0);
        chk("glitch_hi_rises", 32'(rises), 0);
        chk("glitch_hi_cnt", 32'(edge_cnt), 1);

        sig_syn = 1'b1; run(4);
        chk("second_rise_cnt", 32'(edge_cnt), 2);
        run(2);
        rises = 0; falls = 0;
        sig_syn = 1'b0; run(3);
        sig_syn = 1'b1; run(5);
        chk("glitch_lo_clean", 32'(sig_clean), 1);
        chk("glitch_lo_falls", 32'(falls), 0);

        // Square wave: 10 periods, 50-cycle halves
        sig_syn = 1'b0; run(6);
        cnt_clr = 1'b1; run(1); cnt_clr = 1'b0;
        chk("clr_cnt", 32'(edge_cnt), 0);
        rises = 0; falls = 0; both = 0;
        for (int p = 0; p < 10; p++) begin
            sig_syn = 1'b1;
            for (int i = 0; i < 50; i++) begin
                run(1);
                if (rise_pulse && i == 3) r3++;
            end
            sig_syn = 1'b0;
            for (int i = 0; i < 50; i++) begin
                run(1);
                if (fall_pulse && i == 3) f3++;
            end
        end
        chk("sq_rises", 32'(rises), 10);
        chk("sq_falls", 32'(falls), 10);
        chk("sq_rise_lag", 32'(r3), 10);
        chk("sq_fall_lag", 32'(f3), 10);
        chk("sq_cnt", 32'(edge_cnt), 10);
        chk("sq_overlap", 32'(both), 0);

        // Clear coinciding with an accepted rise
        sig_syn = 1'b1; run(3);
        cnt_clr = 1'b1; run(1); cnt_clr = 1'b0;
        chk("clr_rise_pulse", 32'(rise_pulse), 1);
        chk("clr_rise_cnt", 32'(edge_cnt), 0);
        chk("clr_rise_clean", 32'(sig_clean), 1);
        sig_syn = 1'b0; run(5);
        sig_syn = 1'b1; run(4);
        chk("post_clr_cnt", 32'(edge_cnt), 1);

        // Reset in WAIT_HI with stab=2 discards the partial count
        sig_syn = 1'b0; run(5);
        sig_syn = 1'b1; run(2);
        rst = 1'b1; run(1);
        chk("midrst_clean", 32'(sig_clean), 0);
        chk("midrst_rise", 32'(rise_pulse), 0);
        chk("midrst_fall", 32'(fall_pulse), 0);
        chk("midrst_cnt", 32'(edge_cnt), 0);
        rst = 1'b0;
        run(3);
        chk("midrst_early", 32'(rise_pulse), 0);
        run(1);
        chk("midrst_rise_late", 32'(rise_pulse), 1);
        chk("midrst_cnt_late", 32'(edge_cnt), 1);

        // Toggle every cycle from IDLE_HI
        rises = 0; falls = 0;
        for (int i = 0; i < 20; i++) begin
            sig_syn = ~sig_syn;
            run(1);
        end
        chk("tog_clean", 32'(sig_clean), 1);
        chk("tog_pulses", 32'(rises + falls), 0);
        chk("tog_cnt", 32'(edge_cnt), 1);

        // Narrow counter: wrap or saturate
`ifdef EDGE_CNT_SAT_EN
        exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd3; exp2[4] = 2'd3;
`else
        exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd0; exp2[4] = 2'd1;
`endif
        for (int k = 0; k < 5; k++) begin
            sig2 = 1'b1; run(4);
            chk($sformatf("cnt2_%0d_pulse", k), 32'(rise2), 1);
            chk($sformatf("cnt2_%0d", k), 32'(cnt2), 32'(exp2[k]));
            sig2 = 1'b0; run(4);
        end
        clr2 = 1'b1; run(1); clr2 = 1'b0;
        chk("cnt2_clr", 32'(cnt2), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
